// File: rtl/core_id_stage.sv
// core_id_stage: instruction decode with a two-entry (output + skid) handshake buffer and load-use interlock.
// Opcode is ins[31:26]; ALU ops occupy 0..25 as {reg, imm} pairs and alu_op is the pair index + 1.
module core_id_stage #(
    parameter int XLEN   = 32,
    parameter int RF_AW  = 4,
    parameter int PC_REG = 15,
    parameter int HAZ_EN = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_valid,
    output logic             if_ready,
    input  logic [31:0]      if_ins,
    input  logic [XLEN-1:0]  if_pc,
    output logic             id_valid,
    input  logic             id_ready,
    input  logic             id_flush,
    input  logic             ex_load,
    input  logic [RF_AW-1:0] ex_rd,
    input  logic [XLEN-1:0]  sr,
    output logic [31:0]      id_ins,
    output logic [XLEN-1:0]  id_pc,
    output logic [XLEN-1:0]  imm,
    output logic [RF_AW-1:0] rfa_addr,
    output logic [RF_AW-1:0] rfb_addr,
    output logic [RF_AW-1:0] rd_addr,
    output logic             rfa_r,
    output logic             rfb_r,
    output logic             rd_w,
    output logic [3:0]       alu_op,
    output logic [1:0]       oprand_mux_a,
    output logic [1:0]       oprand_mux_b,
    output logic             is_load,
    output logic             branch,
    output logic             id_err
);
    localparam int CORE_SR_ZF = 0;
    localparam logic [5:0] OP_NOT = 6'd26, OP_MOV = 6'd28, OP_MOVI = 6'd29, OP_LD = 6'd30,
        OP_ST = 6'd31, OP_B = 6'd32, OP_BI = 6'd33, OP_CALL = 6'd34, OP_CALLI = 6'd35,
        OP_RET = 6'd37, OP_MRS = 6'd40;
    localparam logic [3:0] CORE_ALUOP_NONE = 4'd0, CORE_ALUOP_ADD = 4'd1,
        CORE_ALUOP_NOT = 4'd14, CORE_ALUOP_ERR = 4'd15;
    localparam logic [1:0] CORE_OPMUX_A_NONE = 2'd0, CORE_OPMUX_A_RA = 2'd1, CORE_OPMUX_A_ID_PC = 2'd2;
    localparam logic [1:0] CORE_OPMUX_B_NONE = 2'd0, CORE_OPMUX_B_RB = 2'd1, CORE_OPMUX_B_IMM = 2'd2,
        CORE_OPMUX_B_ID_PC = 2'd3;
    localparam logic [3:0] CORE_BRANCH_B = 4'd0, CORE_BRANCH_BE = 4'd1, CORE_BRANCH_BNE = 4'd2;

    typedef struct packed {
        logic [31:0]      ins;
        logic [XLEN-1:0]  pc;
        logic [XLEN-1:0]  imm;
        logic [RF_AW-1:0] ra;
        logic [RF_AW-1:0] rb;
        logic [RF_AW-1:0] rd;
        logic             a_r;
        logic             b_r;
        logic             w;
        logic [3:0]       alu;
        logic [1:0]       ma;
        logic [1:0]       mb;
        logic             ld;
        logic             br;
        logic             err;
    } dec_t;

    typedef enum logic [1:0] {EMPTY, FULL, SKID} state_t;

    state_t state, state_nx;
    dec_t d, o, s;
    logic ld_in, ld_skid, ld_s, in_hs, out_hs, stall;
    logic [5:0] op;
    logic [3:0] k, code;
    logic [RF_AW-1:0] ra, rb;
    logic alu, alu_r, alu_i, zext, sext16, sext22, has_imm, ra_rd, rb_rd, isb, known, zf;
    logic unused_sr;

    assign op      = if_ins[31:26];
    assign k       = op[4:1];
    assign code    = if_ins[25:22];
    assign ra      = if_ins[25-RF_AW -: RF_AW];
    assign rb      = if_ins[25-2*RF_AW -: RF_AW];
    assign zf      = sr[CORE_SR_ZF];
    assign unused_sr = ^sr;
    assign alu     = op < 6'd26;
    assign alu_r   = alu && !op[0];
    assign alu_i   = alu && op[0];
    assign zext    = alu_i && (k == 4'd3 || k == 4'd5 || k >= 4'd9);
    assign sext16  = (alu_i && !zext) || op inside {OP_MOVI, OP_LD, OP_ST};
    assign sext22  = op inside {OP_BI, OP_CALLI};
    assign has_imm = sext16 || zext || sext22;
    assign ra_rd   = alu_r || op inside {OP_NOT, OP_B, OP_CALL, OP_MOV, OP_ST, OP_RET, OP_MRS};
    assign rb_rd   = alu_r;
    assign isb     = op inside {OP_B, OP_BI};
    assign known   = op <= OP_MRS;

    always_comb begin
        d = '0;
        d.ins = if_ins;
        d.pc = if_pc;
        d.rd = if_ins[25 -: RF_AW];
        d.ra = ra;
        d.rb = rb;
        d.imm = sext22 ? {{(XLEN-22){if_ins[21]}}, if_ins[21:0]} :
                sext16 ? {{(XLEN-16){if_ins[15]}}, if_ins[15:0]} :
                zext   ? {{(XLEN-16){1'b0}}, if_ins[15:0]} : '0;
        d.a_r = ra_rd && ra != RF_AW'(PC_REG);
        d.b_r = rb_rd && rb != RF_AW'(PC_REG);
        d.ma = !ra_rd ? CORE_OPMUX_A_NONE : ra == RF_AW'(PC_REG) ? CORE_OPMUX_A_ID_PC : CORE_OPMUX_A_RA;
        d.mb = rb_rd ? (rb == RF_AW'(PC_REG) ? CORE_OPMUX_B_ID_PC : CORE_OPMUX_B_RB) :
               has_imm ? CORE_OPMUX_B_IMM : CORE_OPMUX_B_NONE;
        d.w = alu || op inside {OP_NOT, OP_MOV, OP_MOVI, OP_LD, OP_MRS};
        d.ld = op == OP_LD;
        d.alu = alu ? k + 4'd1 : op == OP_NOT ? CORE_ALUOP_NOT :
                op inside {OP_LD, OP_ST, OP_B, OP_BI, OP_CALL, OP_CALLI} ? CORE_ALUOP_ADD :
                !known ? CORE_ALUOP_ERR : CORE_ALUOP_NONE;
        d.br = isb && (code == CORE_BRANCH_B || (code == CORE_BRANCH_BE && zf) || (code == CORE_BRANCH_BNE && !zf));
        d.err = !known || (isb && code > CORE_BRANCH_BNE);
    end

    assign stall    = (HAZ_EN != 0) && ex_load && ((o.a_r && o.ra == ex_rd) || (o.b_r && o.rb == ex_rd));
    assign if_ready = state != SKID && !id_flush;
    assign id_valid = state != EMPTY && !stall;
    assign in_hs    = if_valid && if_ready;
    assign out_hs   = id_valid && id_ready;

    always_ff @(posedge clk or negedge rst)
        if (!rst) state <= EMPTY;
        else state <= state_nx;

    always_comb begin
        state_nx = state;
        ld_in = 1'b0;
        ld_skid = 1'b0;
        ld_s = 1'b0;
        if (id_flush) state_nx = EMPTY;
        else case (state)
            EMPTY: if (in_hs) begin
                state_nx = FULL;
                ld_in = 1'b1;
            end
            FULL: if (in_hs) begin
                state_nx = out_hs ? FULL : SKID;
                ld_in = out_hs;
                ld_s = !out_hs;
            end else if (out_hs) state_nx = EMPTY;
            SKID: if (out_hs) begin
                state_nx = FULL;
                ld_skid = 1'b1;
            end
            default: state_nx = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst)
        if (!rst) begin
            o <= '0;
            s <= '0;
        end else begin
            if (ld_in) o <= d;
            else if (ld_skid) o <= s;
            if (ld_s) s <= d;
        end

    assign id_ins       = o.ins;
    assign id_pc        = o.pc;
    assign imm          = o.imm;
    assign rfa_addr     = o.ra;
    assign rfb_addr     = o.rb;
    assign rd_addr      = o.rd;
    assign rfa_r        = o.a_r;
    assign rfb_r        = o.b_r;
    assign rd_w         = o.w;
    assign alu_op       = o.alu;
    assign oprand_mux_a = o.ma;
    assign oprand_mux_b = o.mb;
    assign is_load      = o.ld;
    assign branch       = o.br;
    assign id_err       = o.err;
endmodule

// File: tb/tb_core_id_stage.sv
// tb_core_id_stage: random and directed checks of core_id_stage against a queue-based decode model.
module tb_core_id_stage;
    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [3:0]  ra;
        logic [3:0]  rb;
        logic [3:0]  rd;
        logic        a_r;
        logic        b_r;
        logic        w;
        logic [3:0]  alu;
        logic [1:0]  ma;
        logic [1:0]  mb;
        logic        ld;
        logic        br;
        logic        err;
    } exp_t;

    logic clk = 0, rst = 0;
    logic if_valid = 0, id_ready = 0, id_flush = 0, ex_load = 0;
    logic [31:0] if_ins = 0, if_pc = 0, sr = 0;
    logic [3:0] ex_rd = 0;
    logic if_ready, id_valid, rfa_r, rfb_r, rd_w, is_load, branch, id_err;
    logic [31:0] id_ins, id_pc, imm;
    logic [3:0] rfa_addr, rfb_addr, rd_addr, alu_op;
    logic [1:0] oprand_mux_a, oprand_mux_b;
    logic if_ready0, id_valid0, rfa_r0, rfb_r0, rd_w0, is_load0, branch0, id_err0;
    logic [31:0] id_ins0, id_pc0, imm0;
    logic [3:0] rfa_addr0, rfb_addr0, rd_addr0, alu_op0;
    logic [1:0] oprand_mux_a0, oprand_mux_b0;
    logic [127:0] obs, obs0;
    exp_t q[$];
    int total = 0, bad = 0;

    always #5 clk = ~clk;

    core_id_stage dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready), .if_ins(if_ins), .if_pc(if_pc),
        .id_valid(id_valid), .id_ready(id_ready), .id_flush(id_flush), .ex_load(ex_load), .ex_rd(ex_rd),
        .sr(sr), .id_ins(id_ins), .id_pc(id_pc), .imm(imm), .rfa_addr(rfa_addr), .rfb_addr(rfb_addr),
        .rd_addr(rd_addr), .rfa_r(rfa_r), .rfb_r(rfb_r), .rd_w(rd_w), .alu_op(alu_op),
        .oprand_mux_a(oprand_mux_a), .oprand_mux_b(oprand_mux_b), .is_load(is_load), .branch(branch),
        .id_err(id_err)
    );

    core_id_stage #(.HAZ_EN(0)) dut0 (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready0), .if_ins(if_ins), .if_pc(if_pc),
        .id_valid(id_valid0), .id_ready(id_ready), .id_flush(id_flush), .ex_load(ex_load), .ex_rd(ex_rd),
        .sr(sr), .id_ins(id_ins0), .id_pc(id_pc0), .imm(imm0), .rfa_addr(rfa_addr0), .rfb_addr(rfb_addr0),
        .rd_addr(rd_addr0), .rfa_r(rfa_r0), .rfb_r(rfb_r0), .rd_w(rd_w0), .alu_op(alu_op0),
        .oprand_mux_a(oprand_mux_a0), .oprand_mux_b(oprand_mux_b0), .is_load(is_load0), .branch(branch0),
        .id_err(id_err0)
    );

    assign obs  = {6'b0, id_ins, id_pc, imm, rfa_addr, rfb_addr, rd_addr, rfa_r, rfb_r, rd_w, alu_op,
                   oprand_mux_a, oprand_mux_b, is_load, branch, id_err};
    assign obs0 = {6'b0, id_ins0, id_pc0, imm0, rfa_addr0, rfb_addr0, rd_addr0, rfa_r0, rfb_r0, rd_w0,
                   alu_op0, oprand_mux_a0, oprand_mux_b0, is_load0, branch0, id_err0};

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", tag, got, want);
        end
    endtask

    function automatic exp_t ref_dec(input logic [31:0] ins, input logic [31:0] pc, input logic zf);
        exp_t e;
        int op;
        logic r1, r2, sx, zx, s22;
        e = '0; r1 = 0; r2 = 0; sx = 0; zx = 0; s22 = 0;
        op = int'(ins[31:26]);
        e.ins = ins; e.pc = pc; e.rd = ins[25:22]; e.ra = ins[21:18]; e.rb = ins[17:14];
        if (op < 26) begin
            e.alu = 4'(op / 2 + 1);
            e.w = 1;
            if (op % 2 == 0) r2 = 1;
            else if ((op / 2) inside {3, 5, 9, 10, 11, 12}) zx = 1;
            else sx = 1;
        end else case (op)
            26: begin e.alu = 4'd14; r1 = 1; e.w = 1; end
            28: begin r1 = 1; e.w = 1; end
            29: begin sx = 1; e.w = 1; end
            30: begin e.alu = 4'd1; sx = 1; e.w = 1; e.ld = 1; end
            31: begin e.alu = 4'd1; sx = 1; r1 = 1; end
            32, 33: begin
                e.alu = 4'd1;
                r1 = (op == 32);
                s22 = (op == 33);
                case (ins[25:22])
                    4'd0: e.br = 1;
                    4'd1: e.br = zf;
                    4'd2: e.br = !zf;
                    default: e.err = 1;
                endcase
            end
            34: begin e.alu = 4'd1; r1 = 1; end
            35: begin e.alu = 4'd1; s22 = 1; end
            37: r1 = 1;
            40: begin r1 = 1; e.w = 1; end
            27, 36, 38, 39: ;
            default: begin e.err = 1; e.alu = 4'd15; end
        endcase
        e.a_r = (r1 | r2) && e.ra != 4'd15;
        e.b_r = r2 && e.rb != 4'd15;
        e.ma = !(r1 | r2) ? 2'd0 : e.ra == 4'd15 ? 2'd2 : 2'd1;
        e.mb = r2 ? (e.rb == 4'd15 ? 2'd3 : 2'd1) : (sx | zx | s22) ? 2'd2 : 2'd0;
        e.imm = s22 ? {{10{ins[21]}}, ins[21:0]} : sx ? {{16{ins[15]}}, ins[15:0]} :
                zx ? {16'h0, ins[15:0]} : 32'h0;
        return e;
    endfunction

    function automatic logic [31:0] mk(input int op, input int rd, input int ra, input int rb, input int lo);
        logic [31:0] v;
        v = {6'(op), 4'(rd), 4'(ra), 4'(rb), 14'h0};
        v[15:0] = v[15:0] | 16'(lo);
        return v;
    endfunction

    task automatic cyc();
        logic st, er, ev, ih, oh;
        exp_t nd;
        #4;
        st = q.size() > 0 && ex_load &&
             ((q[0].a_r && q[0].ra == ex_rd) || (q[0].b_r && q[0].rb == ex_rd));
        er = q.size() < 2 && !id_flush;
        ev = q.size() > 0 && !st;
        chk("if_ready", 128'(if_ready), 128'(er));
        chk("id_valid", 128'(id_valid), 128'(ev));
        if (q.size() > 0) chk("head", obs, {6'b0, q[0]});
        ih = if_valid && er;
        oh = ev && id_ready;
        nd = ref_dec(if_ins, if_pc, sr[0]);
        @(posedge clk); #1;
        if (id_flush) q.delete();
        else begin
            if (oh) void'(q.pop_front());
            if (ih) q.push_back(nd);
        end
    endtask

    task automatic put(input logic [31:0] ins, input logic rdy);
        if_valid = 1; if_ins = ins; if_pc = $urandom; id_ready = rdy;
        cyc();
        if_valid = 0;
    endtask

    initial begin
        logic [31:0] i1, i2;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outs", obs, 128'h0);
        chk("rst_valid", 128'(id_valid), 128'h0);
        chk("rst_ready", 128'(if_ready), 128'h1);
        rst = 1;
        cyc();

        put(mk(1, 1, 2, 0, 16'hFFFF), 1);
        chk("addi_valid", 128'(id_valid), 128'h1);
        chk("addi_imm", 128'(imm), 128'hFFFFFFFF);
        chk("addi_muxb", 128'(oprand_mux_b), 128'h2);
        put(mk(23, 3, 4, 0, 16'hFFFF), 1);
        chk("asli_imm", 128'(imm), 128'h0000FFFF);
        cyc();

        i1 = mk(0, 1, 2, 3, 0);
        i2 = mk(2, 4, 5, 6, 0);
        put(i1, 0);
        put(i2, 0);
        chk("skid_ready", 128'(if_ready), 128'h0);
        id_ready = 1;
        #1;
        chk("bp_first", 128'(id_ins), 128'(i1));
        cyc();
        chk("bp_second", 128'(id_ins), 128'(i2));
        chk("bp_second_v", 128'(id_valid), 128'h1);
        cyc();
        chk("bp_drained", 128'(id_valid), 128'h0);

        ex_load = 1; ex_rd = 3;
        i1 = mk(0, 5, 3, 4, 0);
        put(i1, 0);
        chk("stall_valid", 128'(id_valid), 128'h0);
        chk("noint_valid", 128'(id_valid0), 128'h1);
        chk("noint_outs", obs0, {6'b0, ref_dec(i1, id_pc0, 1'b0)});
        cyc();
        chk("stall_hold", 128'(id_ins), 128'(i1));
        chk("stall_valid2", 128'(id_valid), 128'h0);
        ex_load = 0;
        #1;
        chk("unstall_valid", 128'(id_valid), 128'h1);
        id_ready = 1;
        cyc();

        sr = 32'h1;
        put(mk(33, 2, 0, 0, 16'h0040), 1);
        chk("bne_zf1", 128'(branch), 128'h0);
        sr = 32'h0;
        put(mk(33, 2, 0, 0, 16'h0040), 1);
        chk("bne_zf0", 128'(branch), 128'h1);
        put(mk(33, 7, 0, 0, 0), 1);
        chk("bcode_err", 128'(id_err), 128'h1);
        cyc();

        put(mk(4, 1, 1, 1, 0), 0);
        put(mk(6, 2, 2, 2, 0), 0);
        id_flush = 1; if_valid = 1; if_ins = mk(8, 3, 3, 3, 0);
        cyc();
        id_flush = 0; if_valid = 0;
        chk("flush_valid", 128'(id_valid), 128'h0);
        id_ready = 1;
        cyc();
        chk("flush_noacc", 128'(id_valid), 128'h0);

        put(mk(28, 1, 15, 0, 0), 1);
        chk("pc_rfa_r", 128'(rfa_r), 128'h0);
        chk("pc_muxa", 128'(oprand_mux_a), 128'h2);
        cyc();

        for (int i = 0; i < 600; i++) begin
            if_valid = $urandom_range(0, 9) < 7;
            id_ready = $urandom_range(0, 9) < 6;
            id_flush = $urandom_range(0, 19) == 0;
            ex_load = $urandom_range(0, 3) == 0;
            ex_rd = 4'($urandom_range(0, 3));
            sr = $urandom;
            if_pc = $urandom;
            if_ins = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                if_ins[21:18] = 4'($urandom_range(0, 3));
                if_ins[17:14] = 4'($urandom_range(0, 3));
            end
            if ($urandom_range(0, 1) == 1) if_ins[31:26] = 6'($urandom_range(0, 41));
            cyc();
        end

        id_flush = 0; ex_load = 0;
        put(mk(0, 1, 1, 1, 0), 0);
        put(mk(2, 2, 2, 2, 0), 0);
        #2 rst = 0;
        #1;
        chk("arst_outs", obs, 128'h0);
        chk("arst_valid", 128'(id_valid), 128'h0);
        chk("arst_ready", 128'(if_ready), 128'h1);
        @(posedge clk); #1;
        rst = 1;
        q.delete();
        id_ready = 1;
        cyc();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/core_id_stage.md
CORE_ID_STAGE -- requirements
Module: core_id_stage

Interface
REQ-001 SHALL have parameter XLEN, default 32: datapath width of pc, imm and sr.
REQ-002 SHALL have parameter RF_AW, default 4: register index width; fields are rd ins[25:22], ra ins[21:18], rb ins[17:14] at RF_AW=4.
REQ-003 SHALL have parameter PC_REG, default 15: register index that aliases the PC.
REQ-004 SHALL have parameter HAZ_EN, default 1: 1 enables the load-use interlock; 0 disables it.
REQ-005 SHALL have port clk, input, 1: sole clock, rising edge.
REQ-006 SHALL have port rst, input, 1: reset, asynchronous, active-low.
REQ-007 SHALL have ports if_valid in 1, if_ready out 1, if_ins in 32, if_pc in XLEN: fetch handshake.
REQ-008 SHALL have ports id_valid out 1 and id_ready in 1: execute handshake.
REQ-009 SHALL have port id_flush, input, 1: kill all held instructions.
REQ-010 SHALL have ports ex_load in 1 and ex_rd in RF_AW: load occupying execute and its destination register.
REQ-011 SHALL have port sr, input, XLEN: status register; bit CORE_SR_ZF is used.
REQ-012 SHALL have registered outputs with these widths:
- id_ins 32, id_pc XLEN, imm XLEN
- rfa_addr, rfb_addr, rd_addr RF_AW; rfa_r, rfb_r, rd_w 1
- alu_op 4, oprand_mux_a 2, oprand_mux_b 2
- is_load 1, branch 1, id_err 1

Function
REQ-013 SHALL implement a three-state control FSM:
- EMPTY: output register invalid.
- FULL: output register valid.
- SKID: output register valid, plus one instruction held in the skid buffer.
REQ-014 SHALL drive if_ready = (state != SKID) and not id_flush.
REQ-015 An input handshake (if_valid and if_ready) SHALL decode the instruction, registering it into the output register if that register is free or draining, otherwise into the skid buffer.
REQ-016 Latency SHALL be 1 cycle from input handshake to id_valid, when not stalled.
REQ-017 SHALL drive id_valid = (state != EMPTY) and not stall; an output handshake is id_valid and id_ready.
REQ-018 FSM transitions (a simultaneous input and output handshake is a pass-through):
- EMPTY->FULL on input.
- FULL->EMPTY on output without input.
- FULL->SKID on input without output.
- SKID->FULL on output; the skid entry moves to the output register.
REQ-019 stall SHALL be asserted when HAZ_EN=1, ex_load=1 and ((rfa_r and rfa_addr==ex_rd) or (rfb_r and rfb_addr==ex_rd)).
REQ-020 During stall, output contents SHALL be held.
REQ-021 id_flush=1 SHALL, at the next edge, force EMPTY and discard both output and skid entries; flush SHALL win over any same-cycle handshake.
REQ-022 Immediate decode:
- Signed ALU immediates, LD, ST: sign-extend ins[15:0].
- MULUI, DIVUI, RSLI, RSRI, ASLI, ASRI: zero-extend ins[15:0].
- BI, CALLI: sign-extend ins[21:0].
- Otherwise imm=0.
- All extensions are to XLEN.
REQ-023 Register-read decode:
- Two-source ALU ops set rfa_r and rfb_r.
- NOT, B, CALL, MOV, ST, RET, MRS set rfa_r only.
- An ra or rb equal to PC_REG clears the corresponding rf*_r and selects CORE_OPMUX_*_ID_PC.
REQ-024 Operand mux select:
- oprand_mux_b: RB when rb is read, else IMM when an immediate is selected, else NONE.
- oprand_mux_a: RA when ra is read, else NONE.
REQ-025 rd_w SHALL be 1 for ALU ops, MOV, MOVI, LD, MRS; is_load SHALL be 1 for LD.
REQ-026 alu_op SHALL map each opcode pair (reg/imm) to its CORE_ALUOP_*:
- LD, ST, B, BI, CALL, CALLI map to ADD.
- NOP, MOV, MOVI, SWI, RET, RFE, MSR, MRS map to NONE.
REQ-027 Branch decode, on B/BI only, using code ins[25:22]:
- CORE_BRANCH_B: branch=1.
- BE: branch=ZF.
- BNE: branch=not ZF.
- Any other code: id_err=1.
- branch SHALL use sr sampled at the decode edge.
REQ-028 An unknown opcode SHALL set id_err=1, alu_op=CORE_ALUOP_ERR and clear rfa_r, rfb_r, rd_w; id_valid SHALL still assert so execute can trap.

Reset
REQ-029 While rst=0, the block SHALL asynchronously force state EMPTY, clear the skid buffer and drive every registered output to 0.
REQ-030 The block SHALL leave reset with id_valid=0 and if_ready=1.
REQ-031 Reset asserted mid-operation SHALL discard all held instructions with no handshake completing.

Verification
REQ-032 Bench SHALL cover immediate extension:
- ADDI with ins[15:0]=0xFFFF, id_ready=1 -> next cycle id_valid=1, imm=0xFFFFFFFF, oprand_mux_b=IMM.
- ASLI with ins[15:0]=0xFFFF -> imm=0x0000FFFF.
REQ-033 Bench SHALL cover backpressure:
- Hold id_ready=0 and issue 2 instructions -> state SKID, if_ready=0.
- Raise id_ready -> both emerge in order on consecutive cycles, none lost.
REQ-034 Bench SHALL cover load-use stall:
- ex_load=1, ex_rd=3; ADD with ra=3 -> id_valid=0 and outputs held while ex_load=1.
- Drop ex_load -> id_valid=1 the same cycle.
- With HAZ_EN=0 -> no stall.
REQ-035 Bench SHALL cover branch condition:
- BI code BNE with ZF=1 -> branch=0; with ZF=0 -> branch=1.
- Unused branch code -> id_err=1.
REQ-036 Bench SHALL cover flush and reset:
- id_flush with state SKID and if_valid=1 -> next cycle id_valid=0 and the input not accepted.
- rst low mid-stream -> all outputs 0 immediately, without waiting for a clock edge.
REQ-037 Bench SHALL cover PC aliasing: MOV with ra=15 -> rfa_r=0, oprand_mux_a=ID_PC.
